sodor1_lockstep_seq: RTL and testbench

Run-sequencer for the Sodor 1-stage lockstep bench. It sits between the constrained instruction generator and the shared imem response bus that feeds both the CoreTop and the sodor1_model. It runs the core reset phase and then issues generated instructions whenever the core fetches. It schedules periodic DUT-vs-model comparison windows, drains with NOPs, and reports pass or fail.

---
 rtl/sodor1_lockstep_seq.sv | 186 ++++++++++++++++++
 tb/tb_sodor1_lockstep_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sodor1_lockstep_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sodor1_lockstep_seq
//  Purpose  : Run sequencer for the Sodor 1-stage lockstep bench. Holds the
//             core and model in reset, feeds generated instructions on each
//             fetch, strobes periodic DUT-vs-model compares, drains with NOPs
//             and reports done / sticky fail.
//  Revision : 1.0 - initial release
// ============================================================================
module sodor1_lockstep_seq #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned CHECK_PERIOD = 4,
  parameter int unsigned MAX_INSTR    = 64,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] gen_instr,
  output logic        gen_ack,
  input  logic        imem_req_valid,
  output logic        core_reset,
  output logic [31:0] imem_resp_data,
  output logic        check_en,
  input  logic        mismatch,
  output logic        done,
  output logic        fail,
  output logic [7:0]  instr_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Counter widths; each counter only needs to hold its load value (N-1).
  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned PER_W = (CHECK_PERIOD > 1) ? $clog2(CHECK_PERIOD) : 1;
  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RESET_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(CHECK_PERIOD - 1);
  localparam logic [DRN_W-1:0] DRN_LOAD  = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [7:0]       CNT_MAX   = 8'(MAX_INSTR);
  localparam logic [7:0]       CNT_LAST  = 8'(MAX_INSTR - 1);

  state_t           state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [7:0]       instr_count_q, instr_count_d;
  logic             chk_pend_q, chk_pend_d;
  logic             fail_q, fail_d;
  logic             issue;

  // Next-state, counter updates and all combinational outputs.
  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    per_cnt_d      = per_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    instr_count_d  = instr_count_q;
    chk_pend_d     = 1'b0;
    fail_d         = fail_q;
    core_reset     = 1'b1;
    imem_resp_data = NOP_INSTR;
    gen_ack        = 1'b0;
    check_en       = chk_pend_q;
    done           = 1'b0;
    // An abort in the same cycle as a fetch suppresses the issue entirely.
    issue          = (state_q == S_RUN) && imem_req_valid && !abort;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RST;
          rst_cnt_d     = RST_LOAD;
          per_cnt_d     = '0;
          instr_count_d = '0;
          fail_d        = 1'b0;
        end
      end
      S_RST: begin
        if (rst_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end
      S_RUN: begin
        core_reset = 1'b0;
        if (issue) begin
          imem_resp_data = gen_instr;
          gen_ack        = 1'b1;
          if (instr_count_q != CNT_MAX) begin
            instr_count_d = instr_count_q + 8'd1;
          end
          // Compare strobe lags the wrapping issue by one cycle so the core
          // has written back the instruction before pc/regfile are compared.
          if (per_cnt_q == PER_LAST) begin
            per_cnt_d  = '0;
            chk_pend_d = 1'b1;
          end else begin
            per_cnt_d = per_cnt_q + PER_W'(1);
          end
          if (instr_count_q == CNT_LAST) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRN_LOAD;
          end
        end
      end
      S_DRAIN: begin
        core_reset = 1'b0;
        if (drain_cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          drain_cnt_d = drain_cnt_q - DRN_W'(1);
        end
      end
      S_CHECK: begin
        core_reset = 1'b0;
        check_en   = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
        if (start) begin
          state_d       = S_RST;
          rst_cnt_d     = RST_LOAD;
          per_cnt_d     = '0;
          instr_count_d = '0;
          fail_d        = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Mismatch only counts while a compare is actually being strobed.
    if (check_en && mismatch) begin
      fail_d = 1'b1;
    end

    // Abort overrides every normal transition; a pending strobe is dropped.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      chk_pend_d = 1'b0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      per_cnt_q     <= '0;
      drain_cnt_q   <= '0;
      instr_count_q <= '0;
      chk_pend_q    <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      per_cnt_q     <= per_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      instr_count_q <= instr_count_d;
      chk_pend_q    <= chk_pend_d;
      fail_q        <= fail_d;
    end
  end

  assign fail        = fail_q;
  assign instr_count = instr_count_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sodor1_lockstep_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sodor1_lockstep_seq
//  Purpose  : Directed vector bench for sodor1_lockstep_seq
//             (RESET_CYCLES=2, CHECK_PERIOD=4, MAX_INSTR=8, DRAIN_CYCLES=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sodor1_lockstep_seq;

  localparam logic [31:0] N = 32'h00000013;
  localparam logic [31:0] G = 32'h002081B3;
  localparam logic [31:0] H = 32'h00500093;

  logic        clk = 1'b0;
  logic        reset, start, abort, imem_req_valid, mismatch;
  logic [31:0] gen_instr;
  logic        gen_ack, core_reset, check_en, done, fail;
  logic [31:0] imem_resp_data;
  logic [7:0]  instr_count;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        start, abort, valid, mism;
    logic [31:0] gi;
    logic [2:0]  st;
    logic        cr;
    logic [31:0] data;
    logic        ack, chk, dn, fl;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  sodor1_lockstep_seq #(
    .RESET_CYCLES(2),
    .CHECK_PERIOD(4),
    .MAX_INSTR   (8),
    .DRAIN_CYCLES(2),
    .NOP_INSTR   (32'h00000013)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .gen_instr     (gen_instr),
    .gen_ack       (gen_ack),
    .imem_req_valid(imem_req_valid),
    .core_reset    (core_reset),
    .imem_resp_data(imem_resp_data),
    .check_en      (check_en),
    .mismatch      (mismatch),
    .done          (done),
    .fail          (fail),
    .instr_count   (instr_count),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic a, input logic v, input logic m,
                     input logic [31:0] gi, input logic [2:0] st, input logic cr,
                     input logic [31:0] data, input logic ack, input logic ck,
                     input logic dn, input logic fl, input logic [7:0] cnt);
    vec_t t;
    t.start = s; t.abort = a; t.valid = v; t.mism = m; t.gi = gi;
    t.st = st; t.cr = cr; t.data = data; t.ack = ack; t.chk = ck;
    t.dn = dn; t.fl = fl; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  initial begin
    int cycles, strobes, acks;
    reset = 1'b1; start = 1'b0; abort = 1'b0; imem_req_valid = 1'b0;
    mismatch = 1'b0; gen_instr = G;

    // ---- Reset held 3 cycles, released with start=0 ----
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_data", imem_resp_data, N);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_check_en", 32'(check_en), 32'd0);
    chk("rst_gen_ack", 32'(gen_ack), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);

    //   st ab va mm gi | state cr data ack chk done fail cnt
    add(1, 0, 0, 0, G,  3'd0, 1, N, 0, 0, 0, 0, 8'd0);  // start sampled
    add(0, 0, 0, 0, G,  3'd1, 1, N, 0, 0, 0, 0, 8'd0);
    add(0, 0, 1, 0, G,  3'd1, 1, N, 0, 0, 0, 0, 8'd0);  // fetch ignored in RST
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd0);  // issue 1
    add(0, 0, 0, 0, G,  3'd2, 0, N, 0, 0, 0, 0, 8'd1);  // no fetch
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd1);  // issue 2
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd2);  // issue 3
    add(0, 0, 1, 0, H,  3'd2, 0, H, 1, 0, 0, 0, 8'd3);  // issue 4
    add(0, 0, 1, 0, H,  3'd2, 0, H, 1, 1, 0, 0, 8'd4);  // strobe 1, issue 5
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd5);  // issue 6
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd6);  // issue 7
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd7);  // issue 8 -> DRAIN
    add(0, 0, 1, 1, G,  3'd3, 0, N, 0, 1, 0, 0, 8'd8);  // strobe 2 with mismatch
    add(0, 0, 1, 1, G,  3'd3, 0, N, 0, 0, 0, 1, 8'd8);  // drain 2
    add(0, 0, 0, 0, G,  3'd4, 0, N, 0, 1, 0, 1, 8'd8);  // final compare
    add(0, 0, 0, 0, G,  3'd5, 0, N, 0, 0, 1, 1, 8'd8);
    add(0, 0, 1, 0, G,  3'd5, 0, N, 0, 0, 1, 1, 8'd8);  // DONE holds
    add(1, 0, 0, 0, G,  3'd5, 0, N, 0, 0, 1, 1, 8'd8);  // restart
    add(0, 0, 0, 0, G,  3'd1, 1, N, 0, 0, 0, 0, 8'd0);  // fail cleared
    add(0, 0, 1, 0, G,  3'd1, 1, N, 0, 0, 0, 0, 8'd0);
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd0);
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd1);
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd2);
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd3);
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 1, 0, 0, 8'd4);
    add(0, 1, 1, 0, G,  3'd2, 0, N, 0, 0, 0, 0, 8'd5);  // abort in issue cycle
    add(0, 0, 1, 0, G,  3'd0, 1, N, 0, 0, 0, 0, 8'd5);
    add(1, 0, 0, 0, G,  3'd0, 1, N, 0, 0, 0, 0, 8'd5);
    add(0, 0, 0, 1, G,  3'd1, 1, N, 0, 0, 0, 0, 8'd0);
    add(0, 0, 0, 1, G,  3'd1, 1, N, 0, 0, 0, 0, 8'd0);
    add(0, 0, 0, 1, G,  3'd2, 0, N, 0, 0, 0, 0, 8'd0);  // mismatch w/o strobe
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd0);
    add(0, 0, 1, 0, G,  3'd2, 0, G, 1, 0, 0, 0, 8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].start; abort = vecs[i].abort;
      imem_req_valid = vecs[i].valid; mismatch = vecs[i].mism;
      gen_instr = vecs[i].gi;
      #1;
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d_core_reset", i), 32'(core_reset), 32'(vecs[i].cr));
      chk($sformatf("v%0d_data", i), imem_resp_data, vecs[i].data);
      chk($sformatf("v%0d_gen_ack", i), 32'(gen_ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d_check_en", i), 32'(check_en), 32'(vecs[i].chk));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("v%0d_fail", i), 32'(fail), 32'(vecs[i].fl));
      chk($sformatf("v%0d_count", i), 32'(instr_count), 32'(vecs[i].cnt));
    end

    // ---- Reset mid-run (count=2) ----
    @(negedge clk); reset = 1'b1; start = 1'b0; abort = 1'b0; mismatch = 1'b0;
    imem_req_valid = 1'b1;
    @(negedge clk); reset = 1'b0; imem_req_valid = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    chk("midrst_count", 32'(instr_count), 32'd0);
    chk("midrst_check_en", 32'(check_en), 32'd0);
    chk("midrst_data", imem_resp_data, N);

    // ---- Full run, fetch always valid, mismatch always high ----
    @(negedge clk); start = 1'b1; imem_req_valid = 1'b1; mismatch = 1'b1;
    cycles = 0; strobes = 0; acks = 0;
    @(posedge clk);
    while (cycles < 100) begin
      @(negedge clk); start = 1'b0;
      #1;
      if (done) break;
      if (check_en) strobes++;
      if (gen_ack) acks++;
      cycles++;
    end
    chk("run_done_reached", 32'(done), 32'd1);
    chk("run_cycles", 32'(cycles), 32'd13);
    chk("run_strobes", 32'(strobes), 32'd3);
    chk("run_acks", 32'(acks), 32'd8);
    chk("run_count", 32'(instr_count), 32'd8);
    chk("run_fail", 32'(fail), 32'd1);

    // ---- Reset from DONE clears the sticky fail ----
    @(negedge clk); reset = 1'b1; mismatch = 1'b0; imem_req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("donerst_fail", 32'(fail), 32'd0);
    chk("donerst_done", 32'(done), 32'd0);
    chk("donerst_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
